mem_copy_dma: RTL and testbench
===============================

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter: ADDR_W, 8, address width; the memory holds 2^ADDR_W rows.
REQ-002 Parameter: DATA_W, 8, data width of one memory row.
REQ-003 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  copy request; sampled only in IDLE.
REQ-007 src_addr  input  ADDR_W  first source address; latched on accept.
REQ-008 dst_addr  input  ADDR_W  first destination address; latched on accept.
REQ-009 len  input  ADDR_W  byte count; latched on accept; 0 means no transfer.
REQ-010 abort  input  1  terminates an active copy.
REQ-011 busy  output  1  high in RD and WR states.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 count  output  ADDR_W  bytes written so far in the current or last copy.
REQ-014 mem_cs  output  1  memory chip select.
REQ-015 mem_rd_wr  output  1  memory direction: 1 = write, 0 = read.
REQ-016 mem_addr  output  ADDR_W  memory address.
REQ-017 mem_wdata  output  DATA_W  memory write data.
REQ-018 mem_rdata  input  DATA_W  memory read data; combinational while mem_cs=1 and mem_rd_wr=0.

Function
REQ-019 The block SHALL implement four states: IDLE, RD, WR and DONE.
REQ-020 IDLE: start=1 with len!=0 SHALL latch src, dst and len, clear count and the byte index, and go to RD; start=1 with len=0 SHALL clear count and go to DONE; otherwise stay in IDLE.
REQ-021 RD SHALL drive mem_cs=1, mem_rd_wr=0 and mem_addr=(src+idx) mod 2^ADDR_W, capture mem_rdata into a data buffer at the cycle-ending edge, and go to WR.
REQ-022 WR SHALL drive mem_cs=1, mem_rd_wr=1, mem_addr=(dst+idx) mod 2^ADDR_W and mem_wdata=buffer, then at the edge increment idx and count.
REQ-023 WR SHALL go to DONE when idx+1 equals len, otherwise back to RD.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-025 Outside RD and WR, mem_cs, mem_rd_wr, mem_addr and mem_wdata SHALL be 0.
REQ-026 Memory-side outputs SHALL be combinational decodes of registered state only, except for abort gating per REQ-030.
REQ-027 Timing: for len=N, with cycle 1 being the first cycle after the accept edge, byte k SHALL be read in cycle 2k+1 and written in cycle 2k+2, and done SHALL be high in cycle 2N+1; for len=0, done SHALL be high in cycle 1.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_W; no error is flagged on wrap.
REQ-029 Bytes SHALL be copied in ascending index order regardless of src/dst overlap, so a forward overlap (dst>src) replicates the source bytes.
REQ-030 abort=1 in RD or WR SHALL combinationally force mem_cs=0 in that cycle, suppressing the write; at the edge the block SHALL go to IDLE without a done pulse and keep count.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 start is ignored outside IDLE, including in DONE; abort has priority over start.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE, and busy, done, count, idx, the buffer and all memory outputs SHALL be 0 from the next cycle, regardless of state.
REQ-034 Reset mid-copy SHALL suppress further memory accesses and SHALL NOT pulse done.

Verification
REQ-035 Bench SHALL preload mem[0x10..0x13]={A1,B2,C3,D4} and start src=0x10 dst=0x80 len=4 -> mem[0x80..0x83]={A1,B2,C3,D4}, done in cycle 9, count=4, busy high in cycles 1-8.
REQ-036 Bench SHALL start with len=0 -> done in cycle 1, mem_cs never asserted, count=0.
REQ-037 Bench SHALL start src=0xFE dst=0x40 len=4 -> reads at FE,FF,00,01 in that order, and mem[0x40..0x43] holds those bytes.
REQ-038 Bench SHALL preload mem[0x20]=5A and start src=0x20 dst=0x21 len=3 -> mem[0x21..0x23]=5A.
REQ-039 Bench SHALL copy len=8, assert abort in cycle 6 (WR of byte 2) -> no write in cycle 6, IDLE next, count=2, no done pulse, mem[dst+2] unchanged.
REQ-040 Bench SHALL assert rst in cycle 3 of a len=4 copy, and pulse start during cycle 2 -> outputs 0 next cycle, count=0, no done, only byte 0 written, and the cycle-2 start is ignored.

Source files
------------

// File: rtl/mem_copy_dma.sv
// ---------------------------------------------------------------------------
// mem_copy_dma
//
// Copies len rows from src_addr.. to dst_addr.. over a single-port memory,
// one read cycle followed by one write cycle per row. Addresses wrap modulo
// 2^ADDR_W. Rows are copied in ascending index order, so a forward overlap
// (dst > src) replicates the leading source rows.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   start      copy request, sampled only in IDLE
//   src_addr   first source address, latched on accept
//   dst_addr   first destination address, latched on accept
//   len        row count, latched on accept; 0 completes with no access
//   abort      terminates an active copy; gates mem_cs in the same cycle
//   busy       high while reading or writing
//   done       one-cycle completion pulse (not raised on abort or reset)
//   count      rows written so far in the current or last copy
//   mem_cs     memory chip select
//   mem_rd_wr  memory direction, 1 = write, 0 = read
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, combinational during a read cycle
// ---------------------------------------------------------------------------
module mem_copy_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] count,
  output logic              mem_cs,
  output logic              mem_rd_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  state_t            state_next;

  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_inc;
  logic [DATA_W-1:0] data_buf;

  assign idx_inc = idx + ADDR_ONE;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Abort only matters while reading or writing, and it
  // wins over the normal progression so no done pulse follows an abort.
  // -------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (len != '0) ? S_RD : S_DONE;
        end
      end
      S_RD: begin
        state_next = abort ? S_IDLE : S_WR;
      end
      S_WR: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (idx_inc == len_q) begin
          state_next = S_DONE;
        end else begin
          state_next = S_RD;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the one-row data buffer is a plain register, so it is reset along
  // with the rest of the datapath; no RAM macro is involved.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      idx      <= '0;
      count    <= '0;
      data_buf <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            // A zero-length request still clears count so it reflects
            // this (empty) copy rather than the previous one.
            idx   <= '0;
            count <= '0;
            if (len != '0) begin
              src_q <= src_addr;
              dst_q <= dst_addr;
              len_q <= len;
            end
          end
        end
        S_RD: begin
          if (!abort) begin
            data_buf <= mem_rdata;
          end
        end
        S_WR: begin
          // An aborted write never reached memory, so it is not counted.
          if (!abort) begin
            idx   <= idx_inc;
            count <= count + ADDR_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: decodes of registered state; abort is the only input allowed to
  // reach the memory interface combinationally, and only through mem_cs.
  // -------------------------------------------------------------------------
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_cs    = 1'b0;
    mem_rd_wr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      S_RD: begin
        busy     = 1'b1;
        mem_cs   = !abort;
        mem_addr = src_q + idx;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_cs    = !abort;
        mem_rd_wr = 1'b1;
        mem_addr  = dst_q + idx;
        mem_wdata = data_buf;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// ---------------------------------------------------------------------------
// tb_mem_copy_dma
//
// Directed bench for mem_copy_dma. A behavioural 256x8 memory sits on the
// memory port; preloads go through the same write process as DUT writes.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_mem_copy_dma;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] len;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] count;
  logic              mem_cs;
  logic              mem_rd_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] mem [256];
  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_copy_dma #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .count    (count),
    .mem_cs   (mem_cs),
    .mem_rd_wr(mem_rd_wr),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_cs && !mem_rd_wr) ? mem[mem_addr] : '0;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (mem_cs && mem_rd_wr) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  // Presents a request for one cycle; returns in cycle 1 after the accept edge.
  task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pre_we = 1'b0;
    src_addr = '0; dst_addr = '0; len = '0; pre_addr = '0; pre_data = '0;
    step();
    step();
    total_cnt++;
    if ({busy, done, mem_cs, mem_rd_wr} !== 4'b0000)
      $display("FAIL reset_ctrl: busy/done/cs/rd_wr got %b expected 0000",
               {busy, done, mem_cs, mem_rd_wr});
    else pass_cnt++;
    total_cnt++;
    if ({count, mem_addr, mem_wdata} !== 24'h0)
      $display("FAIL reset_data: count/addr/wdata got %h expected 000000",
               {count, mem_addr, mem_wdata});
    else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] exp_data [4];
    exp_data = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), exp_data[i]);
    for (int i = 0; i < 4; i++) poke(8'(8'h80 + i), 8'h00);
    launch(8'h10, 8'h80, 8'd4);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      logic       e_busy, e_done, e_cs, e_wr;
      logic [7:0] e_addr, e_wdata;
      int         k;
      k       = (cyc - 1) / 2;
      e_busy  = (cyc <= 8);
      e_done  = (cyc == 9);
      e_cs    = (cyc <= 8);
      e_wr    = (cyc <= 8) && (cyc % 2 == 0);
      e_addr  = (cyc > 8) ? 8'h00 : (e_wr ? 8'(8'h80 + k) : 8'(8'h10 + k));
      e_wdata = e_wr ? exp_data[k] : 8'h00;
      total_cnt++;
      if ({busy, done, mem_cs, mem_rd_wr, mem_addr, mem_wdata} !==
          {e_busy, e_done, e_cs, e_wr, e_addr, e_wdata})
        $display("FAIL basic_cycle%0d: busy/done/cs/wr/addr/wdata got %b%b%b%b %h %h expected %b%b%b%b %h %h",
                 cyc, busy, done, mem_cs, mem_rd_wr, mem_addr, mem_wdata,
                 e_busy, e_done, e_cs, e_wr, e_addr, e_wdata);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if ({done, count} !== {1'b0, 8'd4})
      $display("FAIL basic_end: done/count got %b %0d expected 0 4", done, count);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (mem[8'h80 + i] !== exp_data[i])
        $display("FAIL basic_mem[%0d]: got %h expected %h", i, mem[8'h80 + i], exp_data[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_len_zero();
    launch(8'h33, 8'h44, 8'd0);
    total_cnt++;
    if ({done, busy, mem_cs, count} !== {3'b100, 8'd0})
      $display("FAIL len0_cycle1: done/busy/cs/count got %b%b%b %0d expected 100 0",
               done, busy, mem_cs, count);
    else pass_cnt++;
    // A request presented while in DONE must be ignored.
    src_addr = 8'h10; dst_addr = 8'h60; len = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if ({done, busy, mem_cs} !== 3'b000)
      $display("FAIL len0_start_in_done: done/busy/cs got %b%b%b expected 000",
               done, busy, mem_cs);
    else pass_cnt++;
    step();
  endtask

  task automatic test_wrap();
    logic [7:0] rd_exp [4];
    logic [7:0] data_exp [4];
    rd_exp   = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    data_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) poke(rd_exp[i], data_exp[i]);
    for (int i = 0; i < 4; i++) poke(8'(8'h40 + i), 8'h00);
    launch(8'hFE, 8'h40, 8'd4);
    for (int k = 0; k < 4; k++) begin
      total_cnt++;
      if ({mem_cs, mem_rd_wr, mem_addr} !== {2'b10, rd_exp[k]})
        $display("FAIL wrap_read%0d: cs/wr/addr got %b%b %h expected 10 %h",
                 k, mem_cs, mem_rd_wr, mem_addr, rd_exp[k]);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({mem_cs, mem_rd_wr, mem_addr, mem_wdata} !== {2'b11, 8'(8'h40 + k), data_exp[k]})
        $display("FAIL wrap_write%0d: cs/wr/addr/wdata got %b%b %h %h expected 11 %h %h",
                 k, mem_cs, mem_rd_wr, mem_addr, mem_wdata, 8'(8'h40 + k), data_exp[k]);
      else pass_cnt++;
      step();
    end
    total_cnt++;
    if (done !== 1'b1) $display("FAIL wrap_done: got %b expected 1", done);
    else pass_cnt++;
    step();
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (mem[8'h40 + i] !== data_exp[i])
        $display("FAIL wrap_mem[%0d]: got %h expected %h", i, mem[8'h40 + i], data_exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_overlap();
    poke(8'h20, 8'h5A);
    poke(8'h21, 8'h01);
    poke(8'h22, 8'h02);
    poke(8'h23, 8'h03);
    launch(8'h20, 8'h21, 8'd3);
    for (int i = 0; i < 6; i++) step();
    total_cnt++;
    if ({done, count} !== {1'b1, 8'd3})
      $display("FAIL overlap_done: done/count got %b %0d expected 1 3", done, count);
    else pass_cnt++;
    step();
    for (int i = 1; i <= 3; i++) begin
      total_cnt++;
      if (mem[8'h20 + i] !== 8'h5A)
        $display("FAIL overlap_mem[%0d]: got %h expected 5a", i, mem[8'h20 + i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    poke(8'h90, 8'hEE);
    poke(8'h91, 8'hEE);
    poke(8'h92, 8'hEE);
    launch(8'h10, 8'h90, 8'd8);
    for (int i = 0; i < 5; i++) step();
    // Cycle 6: write of byte 2.
    abort = 1'b1;
    #1;
    total_cnt++;
    if ({busy, mem_cs, mem_rd_wr} !== 3'b101)
      $display("FAIL abort_gate: busy/cs/wr got %b%b%b expected 101", busy, mem_cs, mem_rd_wr);
    else pass_cnt++;
    @(posedge clk);
    #1;
    abort = 1'b0;
    total_cnt++;
    if ({busy, done, mem_cs, count} !== {3'b000, 8'd2})
      $display("FAIL abort_idle: busy/done/cs/count got %b%b%b %0d expected 000 2",
               busy, done, mem_cs, count);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      step();
      total_cnt++;
      if ({busy, done} !== 2'b00)
        $display("FAIL abort_quiet%0d: busy/done got %b%b expected 00", i, busy, done);
      else pass_cnt++;
    end
    total_cnt++;
    if ({mem[8'h90], mem[8'h91], mem[8'h92]} !== 24'hA1B2EE)
      $display("FAIL abort_mem: got %h %h %h expected a1 b2 ee",
               mem[8'h90], mem[8'h91], mem[8'h92]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) poke(8'(8'hA0 + i), 8'hEE);
    launch(8'h10, 8'hA0, 8'd4);
    step();
    // Cycle 2 (write of byte 0): a new request here must be ignored.
    src_addr = 8'h50; dst_addr = 8'h60; len = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    total_cnt++;
    if ({mem_cs, mem_rd_wr, mem_addr} !== {2'b10, 8'h11})
      $display("FAIL rstmid_ignore_start: cs/wr/addr got %b%b %h expected 10 11",
               mem_cs, mem_rd_wr, mem_addr);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++;
    if ({busy, done, mem_cs, mem_rd_wr, count, mem_addr, mem_wdata} !== 28'h0)
      $display("FAIL rstmid_outputs: busy/done/cs/wr count addr wdata got %b%b%b%b %h %h %h expected all 0",
               busy, done, mem_cs, mem_rd_wr, count, mem_addr, mem_wdata);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if ({busy, done, mem_cs} !== 3'b000)
        $display("FAIL rstmid_quiet%0d: busy/done/cs got %b%b%b expected 000", i, busy, done, mem_cs);
      else pass_cnt++;
    end
    total_cnt++;
    if ({mem[8'hA0], mem[8'hA1], mem[8'hA2], mem[8'hA3]} !== 32'hA1EEEEEE)
      $display("FAIL rstmid_mem: got %h %h %h %h expected a1 ee ee ee",
               mem[8'hA0], mem[8'hA1], mem[8'hA2], mem[8'hA3]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_wrap();
    test_overlap();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
